imem_loader: RTL and testbench

Sequential loader that fills the 16-bit instruction memory from an external byte stream before the single-cycle core runs. It sits between a host byte source (UART/testbench) and the write side of the instruction memory. It assembles `BPW` bytes into one `WIDTH`-bit word and writes words at consecutive word-aligned byte addresses starting at 0. It holds the core in reset-hold until the program is loaded.

---
 rtl/imem_loader_if.sv | 36 +++
 rtl/imem_loader.sv | 146 ++++++++++++++
 tb/tb_imem_loader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream, memory write and status bundle for imem_loader
// Groups every loader signal except clk/reset.
//   host side  : start, word_count, in_data, in_valid -> loader; in_ready <- loader
//   memory side: mem_we, mem_addr, mem_wdata <- loader
//   status     : cpu_hold, busy, done, error <- loader
// master = host/memory/core side, slave = the loader itself.
interface imem_loader_if #(
   parameter int DEPTH = 16,
   parameter int BPW   = 2,
   parameter int WIDTH = 8 * BPW,
   parameter int AW    = $clog2(DEPTH * BPW),
   parameter int CW    = $clog2(DEPTH + 1)
);
   logic             start;
   logic [CW-1:0]    word_count;
   logic [7:0]       in_data;
   logic             in_valid;
   logic             in_ready;
   logic             mem_we;
   logic [AW-1:0]    mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic             cpu_hold;
   logic             busy;
   logic             done;
   logic             error;

   modport master (
      output start, word_count, in_data, in_valid,
      input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error
   );

   modport slave (
      input  start, word_count, in_data, in_valid,
      output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error
   );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads the instruction memory from a byte stream, holding the core meanwhile
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : imem_loader_if.slave (byte stream in, memory write out, status out)
// Bytes are packed big-endian into WIDTH-bit words and written at byte
// addresses 0, BPW, 2*BPW, ... One WRITE cycle follows each assembled word.
module imem_loader #(
   parameter int DEPTH = 16,
   parameter int BPW   = 2,
   parameter int WIDTH = 8 * BPW,
   parameter int AW    = $clog2(DEPTH * BPW),
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   imem_loader_if.slave  bus
);

   // byte index needs at least one bit even when a word is a single byte
   localparam int               BIW       = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [CW-1:0]    DEPTH_C   = CW'(DEPTH);
   localparam logic [BIW-1:0]   LAST_BYTE = BIW'(BPW - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RECV  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state;
   state_t           nstate;
   logic [CW-1:0]    count_r;
   logic [CW-1:0]    word_idx;
   logic [BIW-1:0]   byte_idx;
   logic [WIDTH-1:0] wdata_r;
   logic             error_r;

   logic cnt_zero;
   logic cnt_legal;
   logic can_start;
   logic byte_fire;
   logic last_byte;
   logic last_word;

   assign cnt_zero  = (bus.word_count == '0);
   assign cnt_legal = !cnt_zero && (bus.word_count <= DEPTH_C);
   // start is only honoured when no load is in flight
   assign can_start = bus.start && ((state == S_IDLE) || (state == S_DONE));
   // in_ready is decoded from state alone, so this is the transfer condition
   assign byte_fire = (state == S_RECV) && bus.in_valid;
   assign last_byte = (byte_idx == LAST_BYTE);
   assign last_word = (word_idx == count_r - CW'(1));

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= nstate;
      end
   end

   // next-state logic
   always_comb begin
      nstate = state;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               if (cnt_legal) begin
                  nstate = S_RECV;
               end else if (cnt_zero) begin
                  nstate = S_DONE;
               end
            end
         end
         S_RECV: begin
            if (byte_fire && last_byte) begin
               nstate = S_WRITE;
            end
         end
         S_WRITE: begin
            nstate = last_word ? S_DONE : S_RECV;
         end
         S_DONE: begin
            if (bus.start) begin
               if (cnt_legal) begin
                  nstate = S_RECV;
               end else if (!cnt_zero) begin
                  nstate = S_IDLE;
               end
            end
         end
         default: nstate = S_IDLE;
      endcase
   end

   // datapath: count, indices, assembly register and sticky error flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_r  <= '0;
         word_idx <= '0;
         byte_idx <= '0;
         wdata_r  <= '0;
         error_r  <= 1'b0;
      end else begin
         if (can_start) begin
            if (cnt_legal) begin
               count_r  <= bus.word_count;
               word_idx <= '0;
               byte_idx <= '0;
               error_r  <= 1'b0;
            end else if (cnt_zero) begin
               error_r  <= 1'b0;
            end else begin
               error_r  <= 1'b1;
            end
         end
         if (byte_fire) begin
            // shift left by one byte; after BPW bytes the first byte sits on top
            wdata_r  <= WIDTH'({wdata_r, bus.in_data});
            byte_idx <= last_byte ? '0 : byte_idx + BIW'(1);
         end
         if (state == S_WRITE) begin
            byte_idx <= '0;
            if (!last_word) begin
               word_idx <= word_idx + CW'(1);
            end
         end
      end
   end

   // outputs decoded from registered state
   always_comb begin
      bus.in_ready  = (state == S_RECV);
      bus.mem_we    = (state == S_WRITE);
      bus.busy      = (state == S_RECV) || (state == S_WRITE);
      bus.cpu_hold  = (state != S_DONE);
      bus.done      = (state == S_DONE);
      bus.error     = error_r;
      bus.mem_addr  = AW'(word_idx * BPW);
      bus.mem_wdata = wdata_r;
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   imem_loader_if bus ();

   imem_loader dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // write log captured mid-cycle
   logic [4:0]  wa[$];
   logic [15:0] wd[$];
   int          wt[$];
   int          rdy_viol = 0;

   always @(negedge clk) begin
      if (bus.mem_we) begin
         wa.push_back(bus.mem_addr);
         wd.push_back(bus.mem_wdata);
         wt.push_back(cyc);
         if (bus.in_ready) rdy_viol++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // {cpu_hold, in_ready, mem_we, busy, done, error}
   function automatic logic [5:0] st();
      return {bus.cpu_hold, bus.in_ready, bus.mem_we, bus.busy, bus.done, bus.error};
   endfunction

   task automatic start_load(input int wc);
      bus.word_count = 5'(wc);
      bus.start      = 1'b1;
      tick;
      bus.start      = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic acc;
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < 50 && !acc; i++) begin
         acc = bus.in_ready;
         tick;
      end
      chk("byte_accepted", {31'b0, acc}, 32'd1);
   endtask

   task automatic clear_log;
      wa.delete();
      wd.delete();
      wt.delete();
   endtask

   logic [15:0] exp3 [3];
   logic [7:0]  b16 [32];
   int          k;
   logic        acc;

   initial begin
      bus.start      = 1'b0;
      bus.word_count = '0;
      bus.in_data    = '0;
      bus.in_valid   = 1'b0;
      exp3[0] = 16'h1234;
      exp3[1] = 16'h5678;
      exp3[2] = 16'h9ABC;

      // reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_status", st(), 6'b100000);
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_wdata", bus.mem_wdata, 0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("idle_status", st(), 6'b100000);
      end

      // three words back-to-back
      start_load(3);
      chk("recv_status", st(), 6'b110100);
      send_byte(8'h12);
      send_byte(8'h34);
      send_byte(8'h56);
      send_byte(8'h78);
      send_byte(8'h9A);
      send_byte(8'hBC);
      chk("last_write_status", st(), 6'b101100);
      chk("last_write_addr", bus.mem_addr, 4);
      chk("last_write_data", bus.mem_wdata, 16'h9ABC);
      bus.in_valid = 1'b0;
      tick;
      chk("load3_done_status", st(), 6'b000010);
      chk("load3_write_count", wa.size(), 3);
      for (int i = 0; i < wa.size() && i < 3; i++) begin
         chk("load3_addr", wa[i], 2 * i);
         chk("load3_data", wd[i], exp3[i]);
         if (i > 0) chk("load3_spacing", wt[i] - wt[i-1], 3);
      end
      clear_log();

      // sixteen words, in_valid every other cycle; start from DONE reloads
      for (int i = 0; i < 32; i++) b16[i] = 8'(i * 37 + 5);
      start_load(16);
      chk("reload_status", st(), 6'b110100);
      k = 0;
      for (int c = 0; c < 400 && !bus.done; c++) begin
         bus.in_valid = (c % 2 == 0) && (k < 32);
         bus.in_data  = b16[(k < 32) ? k : 0];
         acc = bus.in_valid && bus.in_ready;
         tick;
         if (acc) k++;
      end
      bus.in_valid = 1'b0;
      chk("load16_done", {31'b0, bus.done}, 1);
      chk("load16_bytes", k, 32);
      chk("load16_write_count", wa.size(), 16);
      for (int i = 0; i < wa.size() && i < 16; i++) begin
         chk("load16_addr", wa[i], 2 * i);
         chk("load16_data", wd[i], {b16[2*i], b16[2*i+1]});
      end
      chk("ready_during_write", rdy_viol, 0);
      clear_log();

      // illegal count, then zero count
      start_load(17);
      chk("illegal_status", st(), 6'b100001);
      repeat (3) tick;
      chk("illegal_hold_status", st(), 6'b100001);
      chk("illegal_no_write", wa.size(), 0);
      start_load(0);
      chk("zero_status", st(), 6'b000010);
      tick;
      chk("zero_no_write", wa.size(), 0);

      // reset in the middle of a four-word load
      start_load(4);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h44);
      send_byte(8'h55);
      bus.in_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("midrst_status", st(), 6'b100000);
      chk("midrst_addr", bus.mem_addr, 0);
      chk("midrst_wdata", bus.mem_wdata, 0);
      chk("midrst_write_count", wa.size(), 2);
      chk("midrst_last_addr", (wa.size() > 0) ? 32'(wa[wa.size()-1]) : 32'hFFFF, 2);
      clear_log();
      tick;
      reset = 1'b0;
      tick;
      chk("postrst_status", st(), 6'b100000);

      // fresh 2-word load; byte alongside start is dropped, start during RECV is ignored
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hEE;
      start_load(2);
      chk("fresh_recv_status", st(), 6'b110100);
      send_byte(8'hA1);
      bus.start      = 1'b1;
      bus.word_count = 5'd1;
      send_byte(8'hB2);
      bus.start      = 1'b0;
      chk("ignored_start_status", st(), 6'b101100);
      chk("fresh_word0", bus.mem_wdata, 16'hA1B2);
      send_byte(8'hC3);
      send_byte(8'hD4);
      chk("fresh_last_write_status", st(), 6'b101100);
      bus.in_valid = 1'b0;
      tick;
      chk("fresh_done_status", st(), 6'b000010);
      chk("fresh_write_count", wa.size(), 2);
      for (int i = 0; i < wa.size() && i < 2; i++) begin
         chk("fresh_addr", wa[i], 2 * i);
      end
      if (wd.size() == 2) begin
         chk("fresh_data0", wd[0], 16'hA1B2);
         chk("fresh_data1", wd[1], 16'hC3D4);
      end
      clear_log();

      // reload from DONE keeps the core held until the load completes
      start_load(1);
      chk("reload1_status", st(), 6'b110100);
      send_byte(8'h5A);
      send_byte(8'h6B);
      chk("reload1_write_status", st(), 6'b101100);
      bus.in_valid = 1'b0;
      tick;
      chk("reload1_done_status", st(), 6'b000010);
      chk("reload1_write_count", wa.size(), 1);
      if (wa.size() == 1) begin
         chk("reload1_addr", wa[0], 0);
         chk("reload1_data", wd[0], 16'h5A6B);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
